// File: rtl/spu_mul_pipe.sv
// rtl/spu_mul_pipe.sv - SIMD 16x16 integer multiply pipeline with stall, partial flush and forwarding taps
// Optional build macro: SPU_MUL_FWD_EN exposes per-stage valid/addr/data on fwd_* (tied to 0 otherwise).
module spu_mul_pipe #(
  parameter int LANES       = 4,
  parameter int LATENCY     = 7,
  parameter int KILL_STAGES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    op_sel,
  input  logic [6:0]                    rt_addr,
  input  logic                          reg_write,
  input  logic [LANES*32-1:0]           ra,
  input  logic [LANES*32-1:0]           rb,
  input  logic [LANES*32-1:0]           rc,
  input  logic [9:0]                    imm,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          wb_valid,
  output logic [LANES*32-1:0]           wb_data,
  output logic [6:0]                    wb_addr,
  output logic                          wb_reg_write,
  output logic                          busy,
  output logic [LATENCY-1:0]            fwd_valid,
  output logic [7*LATENCY-1:0]          fwd_addr,
  output logic [LANES*32*LATENCY-1:0]   fwd_data
);

  localparam int W = LANES * 32;

  localparam logic [2:0] OP_MPY   = 3'd1;
  localparam logic [2:0] OP_MPYU  = 3'd2;
  localparam logic [2:0] OP_MPYH  = 3'd3;
  localparam logic [2:0] OP_MPYA  = 3'd4;
  localparam logic [2:0] OP_MPYI  = 3'd5;
  localparam logic [2:0] OP_MPYUI = 3'd6;
  localparam logic [2:0] OP_MPYS  = 3'd7;

  // One lane: "lo" is the upper half-word of the lane, "hi" the lower one.
  // Operands are widened to 32 bits first so every product is already mod 2^32.
  function automatic logic [31:0] lane_op(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] c,
                                          input logic [9:0]  i10);
    logic [31:0] a_lo_s, a_hi_s, b_lo_s, a_lo_u, b_lo_u, i_s, i_u;
    logic [31:0] p_ss, p_hs, p_is, p_uu, p_ui;
    a_lo_s = {{16{a[31]}}, a[31:16]};
    a_hi_s = {{16{a[15]}}, a[15:0]};
    b_lo_s = {{16{b[31]}}, b[31:16]};
    a_lo_u = {16'd0, a[31:16]};
    b_lo_u = {16'd0, b[31:16]};
    i_s    = {{22{i10[9]}}, i10};
    i_u    = {16'd0, {6{i10[9]}}, i10};
    p_ss   = a_lo_s * b_lo_s;
    p_hs   = a_hi_s * b_lo_s;
    p_is   = a_lo_s * i_s;
    p_uu   = a_lo_u * b_lo_u;
    p_ui   = a_lo_u * i_u;
    case (op)
      OP_MPY:   lane_op = p_ss;
      OP_MPYU:  lane_op = p_uu;
      OP_MPYH:  lane_op = p_hs << 16;
      OP_MPYA:  lane_op = p_ss + c;
      OP_MPYI:  lane_op = p_is;
      OP_MPYUI: lane_op = p_ui;
      OP_MPYS:  lane_op = $unsigned($signed(p_ss) >>> 16);
      default:  lane_op = 32'd0;
    endcase
  endfunction

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_rw;
  logic [6:0]         r_addr [LATENCY];
  logic [W-1:0]       r_data [LATENCY];

  logic [LATENCY-1:0] w_valid_nx;
  logic [LATENCY-1:0] w_rw_nx;
  logic [6:0]         w_addr_nx [LATENCY];
  logic [W-1:0]       w_data_nx [LATENCY];
  logic [W-1:0]       w_result;
  logic               w_accept;

  assign in_ready = !stall;
  assign w_accept = in_valid && !stall && (op_sel != 3'd0);

  // Full result is produced before stage 0; later stages only delay it.
  always_comb begin
    w_result = '0;
    for (int i = 0; i < LANES; i++) begin
      w_result[i*32 +: 32] = lane_op(op_sel, ra[i*32 +: 32], rb[i*32 +: 32], rc[i*32 +: 32], imm);
    end
  end

  // Next stage contents: hold on stall, otherwise shift; flush then kills the youngest stages.
  always_comb begin
    w_valid_nx = r_valid;
    w_rw_nx    = r_rw;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    if (!stall) begin
      w_valid_nx[0] = w_accept;
      w_rw_nx[0]    = w_accept && reg_write;
      w_addr_nx[0]  = w_accept ? rt_addr : 7'd0;
      w_data_nx[0]  = w_accept ? w_result : '0;
      for (int s = 1; s < LATENCY; s++) begin
        w_valid_nx[s] = r_valid[s-1];
        w_rw_nx[s]    = r_rw[s-1];
        w_addr_nx[s]  = r_addr[s-1];
        w_data_nx[s]  = r_data[s-1];
      end
    end
    if (flush) begin
      for (int s = 0; s < KILL_STAGES; s++) begin
        w_valid_nx[s] = 1'b0;
        w_rw_nx[s]    = 1'b0;
        w_addr_nx[s]  = 7'd0;
        w_data_nx[s]  = '0;
      end
    end
  end

  // Stage registers; reset wins over stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_rw    <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_addr[s] <= 7'd0;
        r_data[s] <= '0;
      end
    end else begin
      r_valid <= w_valid_nx;
      r_rw    <= w_rw_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
    end
  end

  assign wb_valid     = r_valid[LATENCY-1];
  assign wb_data      = r_data[LATENCY-1];
  assign wb_addr      = r_addr[LATENCY-1];
  assign wb_reg_write = r_valid[LATENCY-1] && r_rw[LATENCY-1];
  assign busy         = |r_valid;

`ifdef SPU_MUL_FWD_EN
  assign fwd_valid = r_valid;
  for (genvar s = 0; s < LATENCY; s++) begin : g_fwd
    assign fwd_addr[s*7 +: 7] = r_addr[s];
    assign fwd_data[s*W +: W] = r_data[s];
  end
`else
  assign fwd_valid = '0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_spu_mul_pipe.sv
// tb/tb_spu_mul_pipe.sv - directed self-checking bench for spu_mul_pipe
module tb_spu_mul_pipe;

  localparam int LANES   = 4;
  localparam int LATENCY = 7;
  localparam int KILL    = 3;
  localparam int W       = LANES * 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               op_sel;
  logic [6:0]               rt_addr;
  logic                     reg_write;
  logic [W-1:0]             ra, rb, rc;
  logic [9:0]               imm;
  logic                     stall;
  logic                     flush;
  logic                     wb_valid;
  logic [W-1:0]             wb_data;
  logic [6:0]               wb_addr;
  logic                     wb_reg_write;
  logic                     busy;
  logic [LATENCY-1:0]       fwd_valid;
  logic [7*LATENCY-1:0]     fwd_addr;
  logic [W*LATENCY-1:0]     fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic       s_valid [0:31];
  logic       s_stall [0:31];
  logic       s_flush [0:31];
  logic [6:0] s_addr  [0:31];
  logic       s_ready [0:31];
  int           rec_addr[$];
  int           rec_cyc[$];
  logic [W-1:0] rec_data[$];

  always #5 clk = ~clk;

  spu_mul_pipe #(.LANES(LANES), .LATENCY(LATENCY), .KILL_STAGES(KILL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rt_addr(rt_addr), .reg_write(reg_write),
    .ra(ra), .rb(rb), .rc(rc), .imm(imm), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_reg_write(wb_reg_write), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    in_valid = 1'b0; op_sel = 3'd0; rt_addr = 7'd0; reg_write = 1'b0;
    ra = '0; rb = '0; rc = '0; imm = 10'd0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic clear_sched;
    for (int i = 0; i < 32; i++) begin
      s_valid[i] = 1'b0; s_stall[i] = 1'b0; s_flush[i] = 1'b0;
      s_addr[i] = 7'd0; s_ready[i] = 1'b0;
    end
    rec_addr.delete(); rec_cyc.delete(); rec_data.delete();
  endtask

  // Plays the schedule tables one cycle at a time and logs every consumed writeback.
  task automatic run_sched(input int n);
    for (int c = 0; c < n; c++) begin
      in_valid  = s_valid[c];
      op_sel    = s_valid[c] ? 3'd1 : 3'd0;
      rt_addr   = s_addr[c];
      reg_write = 1'b1;
      ra        = {LANES{32'hFFFF_0000}};
      rb        = {LANES{32'h0002_0000}};
      stall     = s_stall[c];
      flush     = s_flush[c];
      #1;
      s_ready[c] = in_ready;
      if (wb_valid && !stall) begin
        rec_addr.push_back(int'(wb_addr));
        rec_cyc.push_back(c);
        rec_data.push_back(wb_data);
      end
      step;
    end
    drive_idle;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive_idle;
    step;
    step;
    reset = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
    n_checks++; if (wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    n_checks++; if (wb_addr !== 7'd0) begin n_fail++; $display("FAIL reset_wb_addr got %0d want 0", wb_addr); end
    n_checks++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_reg_write got %0b want 0", wb_reg_write); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (fwd_valid !== '0 || fwd_addr !== '0 || fwd_data !== '0) begin
      n_fail++; $display("FAIL reset_fwd got valid %b want 0", fwd_valid);
    end
    step;
    n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got busy %0b wb_valid %0b want 0 0", busy, wb_valid); end
  endtask

  // Issues one op and follows it through every stage to writeback.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input logic [9:0] im,
                        input logic rw, input logic [6:0] addr, input logic [W-1:0] exp);
    logic [LATENCY-1:0] exp_fv;
    in_valid = 1'b1; op_sel = op; rt_addr = addr; reg_write = rw;
    ra = a; rb = b; rc = c; imm = im;
    step;
    drive_idle;
    for (int e = 1; e < LATENCY; e++) begin
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL %s early_wb edge %0d got %0b want 0", name, e, wb_valid); end
`ifdef SPU_MUL_FWD_EN
      exp_fv = '0; exp_fv[e-1] = 1'b1;
      n_checks++; if (fwd_valid !== exp_fv) begin n_fail++; $display("FAIL %s fwd_valid edge %0d got %b want %b", name, e, fwd_valid, exp_fv); end
`endif
      step;
    end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL %s wb_valid got %0b want 1", name, wb_valid); end
    n_checks++; if (wb_addr !== addr) begin n_fail++; $display("FAIL %s wb_addr got %0d want %0d", name, wb_addr, addr); end
    n_checks++; if (wb_data !== exp) begin n_fail++; $display("FAIL %s wb_data got %h want %h", name, wb_data, exp); end
    n_checks++; if (wb_reg_write !== rw) begin n_fail++; $display("FAIL %s wb_reg_write got %0b want %0b", name, wb_reg_write, rw); end
`ifdef SPU_MUL_FWD_EN
    exp_fv = '0; exp_fv[LATENCY-1] = 1'b1;
    n_checks++; if (fwd_valid !== exp_fv || fwd_addr[(LATENCY-1)*7 +: 7] !== addr || fwd_data[(LATENCY-1)*W +: W] !== exp) begin
      n_fail++; $display("FAIL %s fwd_last got %b/%0d want %b/%0d", name, fwd_valid, fwd_addr[(LATENCY-1)*7 +: 7], exp_fv, addr);
    end
`endif
    step;
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s drain got wb_valid %0b busy %0b want 0 0", name, wb_valid, busy); end
  endtask

  task automatic test_ops;
    run_op("mpy",   3'd1, {LANES{32'hFFFF_0000}}, {LANES{32'h0002_0000}}, '0, 10'd0, 1'b1, 7'd5, {LANES{32'hFFFF_FFFE}});
    run_op("mpyu",  3'd2, {LANES{32'hFFFF_0000}}, {LANES{32'h0002_0000}}, '0, 10'd0, 1'b1, 7'd6, {LANES{32'h0001_FFFE}});
    run_op("mpyh",  3'd3, {LANES{32'h0000_0003}}, {LANES{32'h0004_0000}}, '0, 10'd0, 1'b1, 7'd7, {LANES{32'h000C_0000}});
    run_op("mpya",  3'd4, {LANES{32'hFFFF_0000}}, {LANES{32'h0002_0000}}, {LANES{32'h0000_0010}}, 10'd0, 1'b1, 7'd8, {LANES{32'h0000_000E}});
    run_op("mpyi",  3'd5, {LANES{32'h0005_0000}}, '0, '0, 10'h3FF, 1'b1, 7'd9, {LANES{32'hFFFF_FFFB}});
    run_op("mpyui", 3'd6, {LANES{32'h0001_0000}}, '0, '0, 10'h3FF, 1'b1, 7'd10, {LANES{32'h0000_FFFF}});
    run_op("mpys",  3'd7, {LANES{32'h4000_0000}}, {LANES{32'h0008_0000}}, '0, 10'd0, 1'b0, 7'd11, {LANES{32'h0000_0002}});
    run_op("lanes", 3'd1, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
           {LANES{32'h0003_0000}}, '0, 10'd0, 1'b1, 7'd12, {32'd12, 32'd9, 32'd6, 32'd3});
  endtask

  task automatic test_back_to_back;
    int nxt;
    int base;
    for (int v = 0; v < 2; v++) begin
      clear_sched;
      nxt = 1;
      for (int c = 0; c < 10; c++) begin
        s_stall[c] = (v == 1) && (c >= 3) && (c <= 5);
        if (nxt <= 7) begin
          s_valid[c] = 1'b1;
          s_addr[c]  = 7'(nxt);
          if (!s_stall[c]) nxt++;
        end
      end
      base = (v == 1) ? 9 : 6;
      run_sched(20);
      n_checks++; if (rec_addr.size() != 7) begin n_fail++; $display("FAIL b2b%0d count got %0d want 7", v, rec_addr.size()); end
      for (int i = 0; i < rec_addr.size() && i < 7; i++) begin
        n_checks++; if (rec_addr[i] != i + 1 || rec_cyc[i] != base + i + 1) begin
          n_fail++; $display("FAIL b2b%0d entry %0d got addr %0d cycle %0d want addr %0d cycle %0d", v, i, rec_addr[i], rec_cyc[i], i + 1, base + i + 1);
        end
      end
      if (rec_data.size() > 0) begin
        n_checks++; if (rec_data[0] !== {LANES{32'hFFFF_FFFE}}) begin n_fail++; $display("FAIL b2b%0d data got %h", v, rec_data[0]); end
      end
      n_checks++; if (s_ready[4] !== (v == 0) || s_ready[2] !== 1'b1) begin
        n_fail++; $display("FAIL b2b%0d in_ready got %0b/%0b want %0b/1", v, s_ready[4], s_ready[2], v == 0);
      end
    end
  endtask

  task automatic test_flush;
    clear_sched;
    for (int c = 0; c < 7; c++) begin
      s_valid[c] = 1'b1;
      s_addr[c]  = 7'(c + 1);
    end
    s_flush[6] = 1'b1;
    run_sched(20);
    n_checks++; if (rec_addr.size() != 4) begin n_fail++; $display("FAIL flush count got %0d want 4", rec_addr.size()); end
    for (int i = 0; i < rec_addr.size() && i < 4; i++) begin
      n_checks++; if (rec_addr[i] != i + 1 || rec_cyc[i] != 7 + i) begin
        n_fail++; $display("FAIL flush entry %0d got addr %0d cycle %0d want addr %0d cycle %0d", i, rec_addr[i], rec_cyc[i], i + 1, 7 + i);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %0b want 0", busy); end
  endtask

  task automatic test_flush_stall;
    clear_sched;
    for (int c = 0; c < 5; c++) begin
      s_valid[c] = 1'b1;
      s_addr[c]  = 7'(c + 1);
    end
    s_valid[5] = 1'b1; s_addr[5] = 7'd9; s_stall[5] = 1'b1; s_flush[5] = 1'b1;
    run_sched(16);
    n_checks++; if (rec_addr.size() != 2) begin n_fail++; $display("FAIL flush_stall count got %0d want 2", rec_addr.size()); end
    for (int i = 0; i < rec_addr.size() && i < 2; i++) begin
      n_checks++; if (rec_addr[i] != i + 1 || rec_cyc[i] != 8 + i) begin
        n_fail++; $display("FAIL flush_stall entry %0d got addr %0d cycle %0d want addr %0d cycle %0d", i, rec_addr[i], rec_cyc[i], i + 1, 8 + i);
      end
    end
    n_checks++; if (s_ready[5] !== 1'b0) begin n_fail++; $display("FAIL flush_stall in_ready got %0b want 0", s_ready[5]); end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; op_sel = 3'd1; rt_addr = 7'(c + 20); reg_write = 1'b1;
      ra = {LANES{32'hFFFF_0000}}; rb = {LANES{32'h0002_0000}};
      step;
    end
    n_checks++; if (wb_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got wb_valid %0b busy %0b want 1 1", wb_valid, busy); end
    stall = 1'b1;
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || wb_addr !== 7'd0 || wb_data !== '0 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_wb got valid %0b addr %0d want 0 0", wb_valid, wb_addr);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready got %0b want 0", in_ready); end
    n_checks++; if (fwd_valid !== '0) begin n_fail++; $display("FAIL mid_reset_fwd got %b want 0", fwd_valid); end
    drive_idle;
    step;
  endtask

  initial begin
    drive_idle;
    reset = 1'b1;
    test_reset;
    test_ops;
    test_back_to_back;
    test_flush;
    test_flush_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
